vga_rect_filler: RTL and testbench

Rectangle-fill controller for the VGA video memory write port. On a start pulse it walks every pixel of a clipped rectangle in raster order and emits one pixel write per accepted transfer: the x/y coordinate, the linear memory address and the colour. It sits between drawing logic (screen clear, sprite boxes, game objects) and the VGA adapter's pixel write interface. Transfers follow a plot/ready handshake.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_address_translator.sv | 26 ++
 rtl/vga_rect_filler.sv | 132 +++++++++++++
 tb/tb_vga_rect_filler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Resolution-dependent constants and FSM state type shared by the VGA rectangle filler.
// Constant functions select between the two supported screen sizes.
package vga_pkg;

  localparam int MAX_X_160 = 160;
  localparam int MAX_Y_160 = 120;
  localparam int XW_160    = 8;
  localparam int YW_160    = 7;
  localparam int AW_160    = 15;

  localparam int MAX_X_320 = 320;
  localparam int MAX_Y_320 = 240;
  localparam int XW_320    = 9;
  localparam int YW_320    = 8;
  localparam int AW_320    = 17;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  function automatic int res_max_x(input bit hi);
    return hi ? MAX_X_320 : MAX_X_160;
  endfunction

  function automatic int res_max_y(input bit hi);
    return hi ? MAX_Y_320 : MAX_Y_160;
  endfunction

  function automatic int res_xw(input bit hi);
    return hi ? XW_320 : XW_160;
  endfunction

  function automatic int res_yw(input bit hi);
    return hi ? YW_320 : YW_160;
  endfunction

  function automatic int res_aw(input bit hi);
    return hi ? AW_320 : AW_160;
  endfunction

endpackage

// File: rtl/vga_address_translator.sv
// Maps an (x, y) pixel coordinate to a linear video memory address, purely combinational.
// Multiplication by the row pitch (160 or 320) is done as a sum of two shifts.
module vga_address_translator
  import vga_pkg::*;
#(
  parameter string RESOLUTION = "160x120",
  localparam bit   HI         = (RESOLUTION == "320x240"),
  localparam int   XW         = res_xw(HI),
  localparam int   YW         = res_yw(HI),
  localparam int   AW         = res_aw(HI)
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic [AW-1:0] mem_address_o
);

  // 160 = 128 + 32, 320 = 256 + 64
  localparam int SH_HI = HI ? 8 : 7;
  localparam int SH_LO = HI ? 6 : 5;

  logic [AW-1:0] y_ext;

  assign y_ext         = AW'(y_i);
  assign mem_address_o = (y_ext << SH_HI) + (y_ext << SH_LO) + AW'(x_i);

endmodule

// File: rtl/vga_rect_filler.sv
// Walks a clipped rectangle in raster order, one pixel write per plot&wr_ready transfer.
// First plot one cycle after start; outputs hold while wr_ready is low; done pulses after the last pixel.
module vga_rect_filler
  import vga_pkg::*;
#(
  parameter string RESOLUTION   = "160x120",
  parameter int    COLOUR_WIDTH = 3,
  localparam bit   HI           = (RESOLUTION == "320x240"),
  localparam int   XW           = res_xw(HI),
  localparam int   YW           = res_yw(HI),
  localparam int   AW           = res_aw(HI),
  localparam int   MAX_X        = res_max_x(HI),
  localparam int   MAX_Y        = res_max_y(HI)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [XW-1:0]           x0,
  input  logic [YW-1:0]           y0,
  input  logic [XW-1:0]           w,
  input  logic [YW-1:0]           h,
  input  logic [COLOUR_WIDTH-1:0] colour,
  input  logic                    wr_ready,
  output logic                    plot,
  output logic [XW-1:0]           x_out,
  output logic [YW-1:0]           y_out,
  output logic [AW-1:0]           mem_address,
  output logic [COLOUR_WIDTH-1:0] colour_out,
  output logic                    busy,
  output logic                    done
);

  state_t                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [XW-1:0]           x0_q, x0_d;
  logic [XW-1:0]           x_end_q, x_end_d;
  logic [YW-1:0]           y_end_q, y_end_d;
  logic [COLOUR_WIDTH-1:0] colour_q, colour_d;

  logic [XW:0]   x_last;
  logic [YW:0]   y_last;
  logic [XW-1:0] x_clip;
  logic [YW-1:0] y_clip;
  logic          empty;

  // One extra bit keeps x0+w-1 from wrapping before the clamp to the screen edge.
  always_comb begin
    x_last = {1'b0, x0} + {1'b0, w} - (XW+1)'(1);
    y_last = {1'b0, y0} + {1'b0, h} - (YW+1)'(1);
    x_clip = (x_last > (XW+1)'(MAX_X - 1)) ? XW'(MAX_X - 1) : x_last[XW-1:0];
    y_clip = (y_last > (YW+1)'(MAX_Y - 1)) ? YW'(MAX_Y - 1) : y_last[YW-1:0];
    empty  = (w == '0) || (h == '0) || (x0 >= XW'(MAX_X)) || (y0 >= YW'(MAX_Y));
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    colour_d = colour_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          colour_d = colour;
          x0_d     = x0;
          x_end_d  = x_clip;
          y_end_d  = y_clip;
          if (empty) begin
            state_d = DONE;
          end else begin
            x_d     = x0;
            y_d     = y0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (wr_ready) begin
          if ((x_q == x_end_q) && (y_q == y_end_q)) begin
            state_d = DONE;
          end else if (x_q == x_end_q) begin
            x_d = x0_q;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      x_end_q  <= x_end_d;
      y_end_q  <= y_end_d;
      colour_q <= colour_d;
    end
  end

  assign plot       = (state_q == FILL);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_q;

  vga_address_translator #(
    .RESOLUTION(RESOLUTION)
  ) u_addr (
    .x_i          (x_q),
    .y_i          (y_q),
    .mem_address_o(mem_address)
  );

endmodule

// File: tb/tb_vga_rect_filler.sv
// Checks the rectangle filler at both resolutions against a raster-order pixel list model.
module tb_vga_rect_filler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // 160x120 instance
  logic       rst_a, start_a, rdy_a, plot_a, busy_a, done_a;
  logic [7:0] x0_a, w_a, xo_a;
  logic [6:0] y0_a, h_a, yo_a;
  logic [2:0] col_a, colo_a;
  logic [14:0] addr_a;

  // 320x240 instance
  logic       rst_b, start_b, rdy_b, plot_b, busy_b, done_b;
  logic [8:0] x0_b, w_b, xo_b;
  logic [7:0] y0_b, h_b, yo_b;
  logic [2:0] col_b, colo_b;
  logic [16:0] addr_b;

  vga_rect_filler #(.RESOLUTION("160x120"), .COLOUR_WIDTH(3)) dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .x0(x0_a), .y0(y0_a), .w(w_a), .h(h_a),
    .colour(col_a), .wr_ready(rdy_a), .plot(plot_a), .x_out(xo_a), .y_out(yo_a),
    .mem_address(addr_a), .colour_out(colo_a), .busy(busy_a), .done(done_a)
  );

  vga_rect_filler #(.RESOLUTION("320x240"), .COLOUR_WIDTH(3)) dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .x0(x0_b), .y0(y0_b), .w(w_b), .h(h_b),
    .colour(col_b), .wr_ready(rdy_b), .plot(plot_b), .x_out(xo_b), .y_out(yo_b),
    .mem_address(addr_b), .colour_out(colo_b), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int x;
    int y;
    int addr;
  } pix_t;

  typedef struct {
    int          x0, y0, w, h, col;
    bit          rnd;
    logic [31:0] pat;
    int          inj;
    int          exp_n, exp_first, exp_last, exp_done;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Raster-order list of on-screen pixels covered by the rectangle.
  function automatic void build_model(input int x0, y0, w, h, mx, my, inout pix_t q[$]);
    q = {};
    for (int y = y0; (y < y0 + h) && (y < my); y++)
      for (int x = x0; (x < x0 + w) && (x < mx); x++)
        q.push_back('{x, y, y * mx + x});
  endfunction

  task automatic run_a(input int x0, y0, w, h, col, input bit rnd, input logic [31:0] pat,
                       input int inj, output int n_plot, output int first_addr,
                       output int last_addr, output int done_c);
    pix_t q[$];
    pix_t e;
    int   c, stalls, npix;
    build_model(x0, y0, w, h, 160, 120, q);
    npix = q.size();
    n_plot = 0; first_addr = -1; last_addr = -1; done_c = -1; stalls = 0;
    @(negedge clk);
    check("idle_before_start", int'({plot_a, busy_a, done_a}), 0);
    start_a = 1'b1; x0_a = 8'(x0); y0_a = 7'(y0); w_a = 8'(w); h_a = 7'(h); col_a = 3'(col);
    rdy_a = 1'b1;
    @(negedge clk);
    for (c = 1; c <= 3000; c++) begin
      if (c == inj) begin
        start_a = 1'b1; x0_a = 8'(x0 + 1); y0_a = 7'd0; w_a = 8'd7; h_a = 7'd9; col_a = ~3'(col);
      end else begin
        start_a = 1'b0;
      end
      rdy_a = rnd ? ($urandom_range(0, 2) != 0) : pat[(c - 1) % 32];
      if (done_a) begin
        done_c = c;
        check("done_cycle", c, npix + stalls + 1);
        check("busy_with_done", int'(busy_a), 1);
        check("plot_with_done", int'(plot_a), 0);
        check("pixels_left", q.size(), 0);
        break;
      end
      if (plot_a) begin
        if (q.size() == 0) begin
          check("extra_plot", 1, 0);
        end else begin
          e = q[0];
          check("x_out", int'(xo_a), e.x);
          check("y_out", int'(yo_a), e.y);
          check("mem_address", int'(addr_a), e.addr);
          check("colour_out", int'(colo_a), col);
          check("busy_in_fill", int'(busy_a), 1);
          if (first_addr < 0) first_addr = int'(addr_a);
          if (rdy_a) begin
            void'(q.pop_front());
            n_plot++;
            last_addr = int'(addr_a);
          end else begin
            stalls++;
          end
        end
      end
      @(negedge clk);
    end
    if (c > 3000) check("timeout_a", 0, 1);
    start_a = 1'b0; rdy_a = 1'b0;
    @(negedge clk);
    check("done_one_cycle", int'(done_a), 0);
    check("busy_after_done", int'(busy_a), 0);
  endtask

  initial begin
    vt[0] = '{10, 5, 3, 2, 5, 1'b0, 32'hFFFF_FFFF, 0, 6, 810, 972, 7};
    vt[1] = '{158, 118, 5, 5, 3, 1'b0, 32'hFFFF_FFFF, 0, 4, 19038, 19199, 5};
    vt[2] = '{20, 30, 2, 1, 4, 1'b0, 32'hFFFF_FFF9, 0, 2, 4820, 4821, 5};
    vt[3] = '{7, 7, 0, 4, 2, 1'b0, 32'hFFFF_FFFF, 0, 0, -1, -1, 1};
    vt[4] = '{200, 10, 4, 4, 1, 1'b0, 32'hFFFF_FFFF, 0, 0, -1, -1, 1};
    vt[5] = '{3, 3, 3, 0, 6, 1'b0, 32'hFFFF_FFFF, 0, 0, -1, -1, 1};
    vt[6] = '{5, 120, 3, 3, 2, 1'b0, 32'hFFFF_FFFF, 0, 0, -1, -1, 1};
    vt[7] = '{159, 119, 1, 1, 6, 1'b0, 32'hFFFF_FFFF, 0, 1, 19199, 19199, 2};
    vt[8] = '{40, 60, 4, 3, 2, 1'b0, 32'hFFFF_FFFF, 3, 12, 9640, 9963, 13};

    rst_a = 1'b1; start_a = 1'b0; rdy_a = 1'b0; x0_a = '0; y0_a = '0; w_a = '0; h_a = '0; col_a = '0;
    rst_b = 1'b1; start_b = 1'b0; rdy_b = 1'b0; x0_b = '0; y0_b = '0; w_b = '0; h_b = '0; col_b = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    check("reset_ctrl_a", int'({plot_a, busy_a, done_a}), 0);
    check("reset_data_a", int'({xo_a, yo_a, colo_a, addr_a}), 0);
    check("reset_ctrl_b", int'({plot_b, busy_b, done_b}), 0);
    check("reset_data_b", int'({xo_b, yo_b, colo_b}), 0);
    check("reset_addr_b", int'(addr_b), 0);

    fork
      begin : thread_a
        int n, f, l, dc, rx0, ry0, rw, rh, exp_n, nx, ny;
        for (int i = 0; i < NV; i++) begin
          run_a(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].col, vt[i].rnd, vt[i].pat, vt[i].inj,
                n, f, l, dc);
          check("vec_n_plot", n, vt[i].exp_n);
          check("vec_first_addr", f, vt[i].exp_first);
          check("vec_last_addr", l, vt[i].exp_last);
          check("vec_done_at", dc, vt[i].exp_done);
        end
        for (int i = 0; i < 25; i++) begin
          rx0 = $urandom_range(0, 170);
          ry0 = $urandom_range(0, 127);
          rw  = $urandom_range(0, 12);
          rh  = $urandom_range(0, 8);
          nx  = (rx0 + rw > 160) ? 160 - rx0 : rw;
          ny  = (ry0 + rh > 120) ? 120 - ry0 : rh;
          exp_n = (nx > 0 && ny > 0) ? nx * ny : 0;
          run_a(rx0, ry0, rw, rh, int'($urandom_range(0, 7)), 1'b1, 32'h0, 0, n, f, l, dc);
          check("rand_n_plot", n, exp_n);
        end
      end
      begin : thread_b
        int c, n, err, last;
        pix_t q[$];
        @(negedge clk);
        start_b = 1'b1; x0_b = 9'd0; y0_b = 8'd0; w_b = 9'd320; h_b = 8'd240; col_b = 3'd6;
        rdy_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0; err = 0; last = -1;
        for (c = 1; c <= 80000; c++) begin
          if (done_b) break;
          if (plot_b) begin
            if (int'(xo_b) != n % 320 || int'(yo_b) != n / 320 ||
                int'(addr_b) != (n / 320) * 320 + n % 320 || colo_b != 3'd6)
              err++;
            last = int'(addr_b);
            n++;
          end
          @(negedge clk);
        end
        check("full_plots", n, 76800);
        check("full_pixel_errors", err, 0);
        check("full_last_addr", last, 76799);
        check("full_done_at", c, 76801);

        @(negedge clk);
        start_b = 1'b1; col_b = 3'd2;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 100; k++) begin
          rdy_b = ($urandom_range(0, 1) != 0);
          @(negedge clk);
        end
        check("midfill_plot", int'(plot_b), 1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0; rdy_b = 1'b1;
        check("after_reset_plot", int'(plot_b), 0);
        check("after_reset_busy", int'(busy_b), 0);
        check("after_reset_done", int'(done_b), 0);
        check("after_reset_addr", int'(addr_b), 0);
        check("after_reset_colour", int'(colo_b), 0);

        build_model(318, 238, 4, 4, 320, 240, q);
        start_b = 1'b1; x0_b = 9'd318; y0_b = 8'd238; w_b = 9'd4; h_b = 8'd4; col_b = 3'd5;
        @(negedge clk);
        start_b = 1'b0;
        for (c = 1; c <= 50; c++) begin
          if (done_b) break;
          if (plot_b) begin
            if (q.size() == 0) check("post_reset_extra_plot", 1, 0);
            else begin
              check("post_reset_addr", int'(addr_b), q[0].addr);
              check("post_reset_colour", int'(colo_b), 5);
              void'(q.pop_front());
            end
          end
          @(negedge clk);
        end
        check("post_reset_done_at", c, 5);
        check("post_reset_left", q.size(), 0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
